// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Control sequencer for a multi-cycle CPU. It steps each instruction through
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the datapath strobes.
//   All strobes are decoded combinationally from the current state and the acks.
//   The only registers are the state, the sticky trap flag and, optionally,
//   the retired-instruction counter.
//
//   Optional feature macro: SEQ_INSTRET_EN
//     When defined, this adds the 32-bit instret output and its counter.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   ctl_regwr/memwr/
//   ctl_memtoreg         decoded controls for the current IR
//   ctl_branch[2:0]      0 = none, 1-6 = conditional, 7 = unconditional jump
//   ctl_illegal          unsupported opcode in the IR
//   branch_taken         comparator result for the IR
//   imem_req/imem_ack    instruction fetch handshake
//   dmem_req/dmem_we/
//   dmem_ack             data access handshake
//   ir_we, pc_we, pc_sel,
//   rf_we                datapath strobes (pc_sel 0 = PC+4, 1 = target)
//   trap                 sticky illegal-instruction flag
//   state[2:0]           current state, for debug only
//   instret[31:0]        retired-instruction count (SEQ_INSTRET_EN only)
module multicycle_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctl_regwr,
    input  logic        ctl_memwr,
    input  logic        ctl_memtoreg,
    input  logic [2:0]  ctl_branch,
    input  logic        ctl_illegal,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        trap,
    output logic [2:0]  state
`ifdef SEQ_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e state_q, state_d;
    logic   trap_q, trap_d;
    logic   mem_op;
    logic   take_target;

    assign mem_op      = ctl_memwr | ctl_memtoreg;
    assign take_target = (ctl_branch == 3'd7) || ((ctl_branch != 3'd0) && branch_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = ctl_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (mem_op)
                    state_d = S_MEM;
                else if (ctl_regwr)
                    state_d = S_WB;
                else begin
                    // Branch or no-writeback op retires straight from EXEC.
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctl_memwr;
                if (dmem_ack) begin
                    if (ctl_memtoreg)
                        state_d = S_WB;
                    else begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;   // encoding 7 is unreachable; recover
        endcase
        // The target is only selected on the cycle that actually writes the PC.
        pc_sel = pc_we & take_target;
    end

    // Set trap together with entry into TRAP, so both become visible in the same cycle.
    assign trap_d = trap_q | ((state_q == S_DECODE) & ctl_illegal);
    assign trap   = trap_q;
    assign state  = state_q;

`ifdef SEQ_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= 32'd0;
        else if (pc_we && (state_q != S_TRAP))
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctl_regwr, ctl_memwr, ctl_memtoreg, ctl_illegal, branch_taken;
    logic [2:0]  ctl_branch;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic        ir_we, pc_we, pc_sel, rf_we, trap;
    logic [2:0]  state;
`ifdef SEQ_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    // Strobe bits: imem_req dmem_req dmem_we ir_we pc_we pc_sel rf_we
    localparam logic [6:0] S_NONE   = 7'b0000000;
    localparam logic [6:0] S_FWAIT  = 7'b1000000;
    localparam logic [6:0] S_FACK   = 7'b1001000;
    localparam logic [6:0] S_MREAD  = 7'b0100000;
    localparam logic [6:0] S_STACK  = 7'b0110100;
    localparam logic [6:0] S_WB     = 7'b0000101;
    localparam logic [6:0] S_WBJ    = 7'b0000111;
    localparam logic [6:0] S_BRT    = 7'b0000110;
    localparam logic [6:0] S_BRN    = 7'b0000100;

    logic [6:0] strb;
    assign strb = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we};

    multicycle_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctl_regwr    (ctl_regwr),
        .ctl_memwr    (ctl_memwr),
        .ctl_memtoreg (ctl_memtoreg),
        .ctl_branch   (ctl_branch),
        .ctl_illegal  (ctl_illegal),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .trap         (trap),
        .state        (state)
`ifdef SEQ_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at the falling edge before this call; outputs are
    // sampled 1 time unit later and the task then advances to the next falling edge.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [6:0] estrb);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(es));
        chk({tag, ".strb"},  32'(strb),  32'(estrb));
        chk({tag, ".trap"},  32'(trap),  32'(es == 3'd6));
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic rw, input logic mw, input logic m2r,
                           input logic [2:0] br, input logic tk);
        ctl_regwr = rw; ctl_memwr = mw; ctl_memtoreg = m2r;
        ctl_branch = br; branch_taken = tk;
    endtask

    initial begin
        rst_n = 1'b0;
        set_ctl(0, 0, 0, 3'd0, 0);
        ctl_illegal = 0; imem_ack = 0; dmem_ack = 0;

        // Reset state, then release between edges
        #1;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.strb",  32'(strb),  32'd0);
        chk("rst.trap",  32'(trap),  32'd0);
`ifdef SEQ_INSTRET_EN
        chk("rst.instret", instret, 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cyc("idle", 3'd0, S_NONE);

        // Fetch wait states, then an ALU op: 1,2,3,5,1
        cyc("fwait0", 3'd1, S_FWAIT);
        cyc("fwait1", 3'd1, S_FWAIT);
        set_ctl(1, 0, 0, 3'd0, 0); imem_ack = 1;
        cyc("alu.f", 3'd1, S_FACK);
        cyc("alu.d", 3'd2, S_NONE);          // ack still high, must be ignored
        imem_ack = 0;
        cyc("alu.e", 3'd3, S_NONE);
        cyc("alu.wb", 3'd5, S_WB);

        // Load, dmem_ack after three wait cycles: 8 cycles total
        set_ctl(1, 0, 1, 3'd0, 0); imem_ack = 1;
        cyc("ld.f", 3'd1, S_FACK);
        imem_ack = 0;
        cyc("ld.d", 3'd2, S_NONE);
        cyc("ld.e", 3'd3, S_NONE);
        cyc("ld.m0", 3'd4, S_MREAD);
        cyc("ld.m1", 3'd4, S_MREAD);
        cyc("ld.m2", 3'd4, S_MREAD);
        dmem_ack = 1;
        cyc("ld.m3", 3'd4, S_MREAD);
        dmem_ack = 0;
        cyc("ld.wb", 3'd5, S_WB);

        // Store, zero-wait: retires from MEM
        set_ctl(0, 1, 0, 3'd0, 0); imem_ack = 1; dmem_ack = 1;
        cyc("st.f", 3'd1, S_FACK);
        cyc("st.d", 3'd2, S_NONE);
        cyc("st.e", 3'd3, S_NONE);
        cyc("st.m", 3'd4, S_STACK);
        dmem_ack = 0;

        // Conditional branch taken, then not taken
        set_ctl(0, 0, 0, 3'd1, 1);
        cyc("bt.f", 3'd1, S_FACK);
        cyc("bt.d", 3'd2, S_NONE);
        cyc("bt.e", 3'd3, S_BRT);
        set_ctl(0, 0, 0, 3'd1, 0);
        cyc("bn.f", 3'd1, S_FACK);
        cyc("bn.d", 3'd2, S_NONE);
        cyc("bn.e", 3'd3, S_BRN);

        // Jump-and-link: target selected on the WB write, even with taken=0
        set_ctl(1, 0, 0, 3'd7, 0);
        cyc("jal.f", 3'd1, S_FACK);
        cyc("jal.d", 3'd2, S_NONE);
        cyc("jal.e", 3'd3, S_NONE);
        cyc("jal.wb", 3'd5, S_WBJ);

        // Illegal opcode: absorbing TRAP, acks ignored
        set_ctl(1, 0, 0, 3'd0, 0);
        cyc("ill.f", 3'd1, S_FACK);
        ctl_illegal = 1;
        cyc("ill.d", 3'd2, S_NONE);
        ctl_illegal = 0; dmem_ack = 1;
        for (int i = 0; i < 100; i++) cyc("trap", 3'd6, S_NONE);
        imem_ack = 0; dmem_ack = 0;
        rst_n = 1'b0;
        cyc("trap.rst", 3'd0, S_NONE);
        rst_n = 1'b1;
        cyc("trap.idle", 3'd0, S_NONE);

        // Reset mid-MEM: dmem_req drops immediately, fetch resumes after IDLE
        set_ctl(1, 0, 1, 3'd0, 0); imem_ack = 1;
        cyc("mr.f", 3'd1, S_FACK);
        imem_ack = 0;
        cyc("mr.d", 3'd2, S_NONE);
        cyc("mr.e", 3'd3, S_NONE);
        #1;
        chk("mr.m.dmem_req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("mr.rst.state",    32'(state),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("mr.idle", 3'd0, S_NONE);
        cyc("mr.fetch", 3'd1, S_FWAIT);

`ifdef SEQ_INSTRET_EN
        // Counter wrap across three branch retires
        dut.instret_q = 32'hFFFFFFFE;
        set_ctl(0, 0, 0, 3'd1, 0); imem_ack = 1;
        cyc("ir0.f", 3'd1, S_FACK);
        cyc("ir0.d", 3'd2, S_NONE);
        cyc("ir0.e", 3'd3, S_BRN);
        chk("instret0", instret, 32'hFFFFFFFF);
        cyc("ir1.f", 3'd1, S_FACK);
        cyc("ir1.d", 3'd2, S_NONE);
        cyc("ir1.e", 3'd3, S_BRN);
        chk("instret1", instret, 32'h00000000);
        cyc("ir2.f", 3'd1, S_FACK);
        cyc("ir2.d", 3'd2, S_NONE);
        cyc("ir2.e", 3'd3, S_BRN);
        chk("instret2", instret, 32'h00000001);
        imem_ack = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
